// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-requester cache-line memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, CMD, BEAT} state_t;
    typedef enum logic {OWN_IC, OWN_DC} owner_t;

    // Byte-offset bits inside one line of 32-bit beats.
    function automatic int off_bits(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the side not granted last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_ic,
    input  logic req_dc,
    input  logic en,
    output logic gnt_ic,
    output logic gnt_dc
);

    owner_t last_grant;

    always_comb begin
        gnt_ic = 1'b0;
        gnt_dc = 1'b0;
        if (en) begin
            if (req_ic && req_dc) begin
                gnt_dc = (last_grant == OWN_IC);
                gnt_ic = (last_grant == OWN_DC);
            end else begin
                gnt_ic = req_ic;
                gnt_dc = req_dc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_IC;
        end else if (gnt_ic) begin
            last_grant <= OWN_IC;
        end else if (gnt_dc) begin
            last_grant <= OWN_DC;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Shares one burst memory port between the I-cache refill and D-cache refill/writeback paths.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic              ic_resp_last,
    input  logic              dc_req_valid,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_we,
    output logic              dc_req_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wdata_ready,
    output logic              dc_resp_valid,
    output logic              dc_resp_last,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wdata_ready
);

    localparam int OFF_W = off_bits(LINE_WORDS);
    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    state_t            state;
    owner_t            owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  beat_cnt;

    logic              arb_en;
    logic              gnt_ic;
    logic              gnt_dc;
    logic              rd_beat;
    logic              wr_beat;
    logic [ADDR_W-1:0] sel_addr;

    // Arbitration is held off during reset so every output reads 0 in the reset cycle.
    assign arb_en   = (state == IDLE) && !rst;
    assign rd_beat  = (state == BEAT) && !we_q && mem_rdata_valid;
    assign wr_beat  = (state == BEAT) && we_q && mem_wdata_ready;
    assign sel_addr = gnt_dc ? dc_req_addr : ic_req_addr;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req_ic (ic_req_valid),
        .req_dc (dc_req_valid),
        .en     (arb_en),
        .gnt_ic (gnt_ic),
        .gnt_dc (gnt_dc)
    );

    assign ic_req_ready   = gnt_ic;
    assign dc_req_ready   = gnt_dc;
    assign dc_wdata_ready = wr_beat && !rst;
    assign mem_wdata      = dc_wdata;
    assign mem_req_valid  = (state == CMD);
    assign mem_req_addr   = addr_q;
    assign mem_req_we     = we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_IC;
            we_q          <= 1'b0;
            addr_q        <= '0;
            beat_cnt      <= '0;
            resp_data     <= '0;
            ic_resp_valid <= 1'b0;
            ic_resp_last  <= 1'b0;
            dc_resp_valid <= 1'b0;
            dc_resp_last  <= 1'b0;
        end else begin
            ic_resp_valid <= rd_beat && (owner == OWN_IC);
            dc_resp_valid <= rd_beat && (owner == OWN_DC);
            ic_resp_last  <= rd_beat && (owner == OWN_IC) && (beat_cnt == LAST_BEAT);
            dc_resp_last  <= rd_beat && (owner == OWN_DC) && (beat_cnt == LAST_BEAT);
            if (rd_beat) begin
                resp_data <= mem_rdata;
            end
            case (state)
                IDLE: begin
                    if (gnt_ic || gnt_dc) begin
                        owner  <= gnt_dc ? OWN_DC : OWN_IC;
                        we_q   <= gnt_dc && dc_req_we;
                        addr_q <= sel_addr & ~OFF_MASK;
                        state  <= CMD;
                    end
                end
                CMD: begin
                    if (mem_req_ready) begin
                        beat_cnt <= '0;
                        state    <= BEAT;
                    end
                end
                BEAT: begin
                    if (rd_beat || wr_beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Randomized bench for mem_arb against a transaction-level model of grants and bursts.
module tb_mem_arb;

    localparam int LW = 4;
    localparam int LINE_BYTES = LW * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_req_valid = 1'b0;
    logic [31:0] ic_req_addr = '0;
    logic        ic_req_ready;
    logic        ic_resp_valid;
    logic        ic_resp_last;
    logic        dc_req_valid = 1'b0;
    logic [31:0] dc_req_addr = '0;
    logic        dc_req_we = 1'b0;
    logic        dc_req_ready;
    logic [31:0] dc_wdata = '0;
    logic        dc_wdata_ready;
    logic        dc_resp_valid;
    logic        dc_resp_last;
    logic [31:0] resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_wdata;
    logic        mem_wdata_ready = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    bit last_dc = 1'b0;

    mem_arb #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
        .clk             (clk),
        .rst             (rst),
        .ic_req_valid    (ic_req_valid),
        .ic_req_addr     (ic_req_addr),
        .ic_req_ready    (ic_req_ready),
        .ic_resp_valid   (ic_resp_valid),
        .ic_resp_last    (ic_resp_last),
        .dc_req_valid    (dc_req_valid),
        .dc_req_addr     (dc_req_addr),
        .dc_req_we       (dc_req_we),
        .dc_req_ready    (dc_req_ready),
        .dc_wdata        (dc_wdata),
        .dc_wdata_ready  (dc_wdata_ready),
        .dc_resp_valid   (dc_resp_valid),
        .dc_resp_last    (dc_resp_last),
        .resp_data       (resp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_we      (mem_req_we),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata),
        .mem_wdata       (mem_wdata),
        .mem_wdata_ready (mem_wdata_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] align(input logic [31:0] a);
        return (a / LINE_BYTES) * LINE_BYTES;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ic_req_valid = 0; dc_req_valid = 0; dc_req_we = 0;
        ic_req_addr = '0; dc_req_addr = '0; dc_wdata = '0;
        mem_req_ready = 0; mem_rdata_valid = 0; mem_rdata = '0; mem_wdata_ready = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        last_dc = 1'b0;
        #2;
    endtask

    // Present requests, check who is granted this cycle, then step into the command cycle.
    task automatic grant(input bit iv, input bit dv, input logic [31:0] ia, input logic [31:0] da,
                         input bit dwe, input bit hold, output bit won_dc);
        bit exp_dc;
        ic_req_valid = iv; dc_req_valid = dv;
        ic_req_addr = ia; dc_req_addr = da; dc_req_we = dwe;
        #1;
        exp_dc = dv && (!iv || !last_dc);
        n_chk++;
        if (dc_req_ready !== exp_dc || ic_req_ready !== (iv && !exp_dc)) begin
            n_fail++;
            $display("FAIL grant: ic_ready=%b dc_ready=%b, required ic=%b dc=%b",
                     ic_req_ready, dc_req_ready, iv && !exp_dc, exp_dc);
        end
        last_dc = exp_dc;
        won_dc = exp_dc;
        @(posedge clk);
        #2;
        if (!hold) begin
            ic_req_valid = 0;
            dc_req_valid = 0;
        end
    endtask

    // Drive the command and beat phases of one burst; mode 0 = every cycle a beat, 1 = random gaps, 2 = pattern.
    task automatic serve(input bit is_dc, input bit we, input logic [31:0] exp_addr, input int stall,
                         input int mode, input logic [15:0] pat, input bit seq_data, output int pulses);
        int k;
        int cyc;
        bit v;
        bit pend;
        bit plast;
        logic [31:0] pdata;
        pulses = 0;
        for (int s = 0; s <= stall; s++) begin
            mem_req_ready = (s == stall);
            mem_rdata_valid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            mem_wdata_ready = 1'($urandom_range(0, 1));
            #2;
            n_chk++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr || mem_req_we !== we) begin
                n_fail++;
                $display("FAIL cmd_hold cycle %0d: valid=%b addr=%h we=%b, required 1 %h %b",
                         s, mem_req_valid, mem_req_addr, mem_req_we, exp_addr, we);
            end
            n_chk++;
            if ({ic_resp_valid, dc_resp_valid, dc_wdata_ready, ic_req_ready, dc_req_ready} !== 5'b0) begin
                n_fail++;
                $display("FAIL cmd_quiet cycle %0d: icv=%b dcv=%b wrdy=%b icr=%b dcr=%b, required all 0",
                         s, ic_resp_valid, dc_resp_valid, dc_wdata_ready, ic_req_ready, dc_req_ready);
            end
            @(posedge clk);
            #2;
        end
        mem_req_ready = 0;
        k = 0; cyc = 0; pend = 0; plast = 0; pdata = '0;
        while (k < LW && cyc < 64) begin
            case (mode)
                0: v = 1'b1;
                1: v = 1'($urandom_range(0, 1));
                default: v = (cyc < 16) ? pat[cyc] : 1'b1;
            endcase
            if (we) begin
                mem_rdata_valid = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                mem_wdata_ready = v;
                dc_wdata = $urandom;
            end else begin
                mem_rdata_valid = v;
                mem_rdata = seq_data ? (32'hA0 + 32'(k)) : $urandom;
                mem_wdata_ready = 1'($urandom_range(0, 1));
            end
            #2;
            n_chk++;
            if (ic_resp_valid !== (pend && !is_dc) || dc_resp_valid !== (pend && is_dc) ||
                ic_resp_last !== (pend && plast && !is_dc) || dc_resp_last !== (pend && plast && is_dc)) begin
                n_fail++;
                $display("FAIL resp_flags beat %0d: icv=%b icl=%b dcv=%b dcl=%b, required valid=%b last=%b owner_dc=%b",
                         k, ic_resp_valid, ic_resp_last, dc_resp_valid, dc_resp_last, pend, pend && plast, is_dc);
            end
            if (pend) begin
                n_chk++;
                if (resp_data !== pdata) begin
                    n_fail++;
                    $display("FAIL resp_data: got %h, required %h", resp_data, pdata);
                end
            end
            n_chk++;
            if (dc_wdata_ready !== (we && v) || mem_wdata !== dc_wdata || mem_req_valid !== 1'b0 ||
                ic_req_ready !== 1'b0 || dc_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL beat_ctrl: wrdy=%b mwdata=%h reqv=%b icr=%b dcr=%b, required wrdy=%b mwdata=%h 0 0 0",
                         dc_wdata_ready, mem_wdata, mem_req_valid, ic_req_ready, dc_req_ready, we && v, dc_wdata);
            end
            if (dc_wdata_ready === 1'b1) pulses++;
            pend = !we && v;
            pdata = mem_rdata;
            plast = (k == LW - 1);
            if (v) k++;
            cyc++;
            @(posedge clk);
            #2;
        end
        n_chk++;
        if (k < LW) begin
            n_fail++;
            $display("FAIL burst_timeout: %0d beats, required %0d", k, LW);
        end
        mem_rdata_valid = 0;
        mem_wdata_ready = 0;
        #2;
        n_chk++;
        if (ic_resp_valid !== (pend && !is_dc) || dc_resp_valid !== (pend && is_dc) ||
            ic_resp_last !== (pend && !is_dc) || dc_resp_last !== (pend && is_dc) || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL final_beat: icv=%b icl=%b dcv=%b dcl=%b reqv=%b, required valid/last=%b owner_dc=%b reqv=0",
                     ic_resp_valid, ic_resp_last, dc_resp_valid, dc_resp_last, mem_req_valid, pend, is_dc);
        end
        if (pend) begin
            n_chk++;
            if (resp_data !== pdata) begin
                n_fail++;
                $display("FAIL final_data: got %h, required %h", resp_data, pdata);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({ic_req_ready, ic_resp_valid, ic_resp_last, dc_req_ready, dc_wdata_ready, dc_resp_valid,
             dc_resp_last, mem_req_valid, mem_req_we} !== 9'b0 || resp_data !== 32'h0 || mem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: flags nonzero or resp_data=%h addr=%h, required all 0", resp_data, mem_req_addr);
        end
    endtask

    task automatic test_ic_read();
        bit w;
        int p;
        do_reset();
        grant(1, 0, 32'h1000_0014, 32'h0, 0, 0, w);
        serve(w, 1'b0, 32'h1000_0010, 0, 0, 16'h0, 1'b1, p);
    endtask

    task automatic test_round_robin();
        bit w;
        int p;
        logic [31:0] ia;
        logic [31:0] da;
        ia = 32'h3000_0008;
        da = 32'h4000_003C;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            grant(1, 1, ia, da, 0, 1, w);
            n_chk++;
            if (w !== ((i % 2) == 0)) begin
                n_fail++;
                $display("FAIL rr_order round %0d: model granted dc=%b, required %b", i, w, (i % 2) == 0);
            end
            serve(w, 1'b0, w ? align(da) : align(ia), 0, 1, 16'h0, 1'b0, p);
        end
        ic_req_valid = 0;
        dc_req_valid = 0;
    endtask

    task automatic test_writeback();
        bit w;
        int p;
        do_reset();
        grant(0, 1, 32'h0, 32'h2000_0040, 1, 0, w);
        serve(w, 1'b1, 32'h2000_0040, 0, 2, 16'b101101, 1'b0, p);
        n_chk++;
        if (p != LW) begin
            n_fail++;
            $display("FAIL write_pulses: got %0d, required %0d", p, LW);
        end
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            mem_rdata_valid = 1;
            mem_wdata_ready = 1;
            mem_rdata = $urandom;
            #2;
            n_chk++;
            if ({ic_resp_valid, dc_resp_valid, dc_wdata_ready, mem_req_valid} !== 4'b0) begin
                n_fail++;
                $display("FAIL idle_ignore cycle %0d: icv=%b dcv=%b wrdy=%b reqv=%b, required all 0",
                         i, ic_resp_valid, dc_resp_valid, dc_wdata_ready, mem_req_valid);
            end
        end
        mem_rdata_valid = 0;
        mem_wdata_ready = 0;
    endtask

    task automatic test_cmd_stall();
        bit w;
        int p;
        grant(1, 0, 32'h7777_777C, 32'h0, 0, 0, w);
        serve(w, 1'b0, 32'h7777_7770, 5, 1, 16'h0, 1'b0, p);
        grant(0, 1, 32'h0, 32'h0ABC_DEF4, 1, 0, w);
        serve(w, 1'b1, 32'h0ABC_DEF0, 5, 1, 16'h0, 1'b0, p);
    endtask

    task automatic test_abort();
        bit w;
        int p;
        logic [31:0] d0;
        do_reset();
        grant(1, 0, 32'h5000_0024, 32'h0, 0, 0, w);
        mem_req_ready = 1;
        @(posedge clk);
        #2;
        mem_req_ready = 0;
        d0 = '0;
        for (int b = 0; b < 3; b++) begin
            mem_rdata_valid = 1;
            mem_rdata = $urandom;
            if (b == 2) rst = 1;
            #2;
            if (b > 0) begin
                n_chk++;
                if (ic_resp_valid !== 1'b1 || resp_data !== d0 || ic_resp_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_pre beat %0d: icv=%b data=%h last=%b, required 1 %h 0",
                             b, ic_resp_valid, resp_data, ic_resp_last, d0);
                end
            end
            d0 = mem_rdata;
            @(posedge clk);
            #2;
        end
        rst = 0;
        mem_rdata_valid = 0;
        last_dc = 1'b0;
        #2;
        n_chk++;
        if ({ic_req_ready, ic_resp_valid, ic_resp_last, dc_req_ready, dc_wdata_ready, dc_resp_valid,
             dc_resp_last, mem_req_valid, mem_req_we} !== 9'b0 || resp_data !== 32'h0 || mem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: icv=%b reqv=%b data=%h addr=%h, required all 0",
                     ic_resp_valid, mem_req_valid, resp_data, mem_req_addr);
        end
        grant(1, 1, 32'h6000_0000, 32'h6100_0018, 0, 0, w);
        serve(w, 1'b0, w ? 32'h6100_0010 : 32'h6000_0000, 0, 1, 16'h0, 1'b0, p);
    endtask

    task automatic test_random();
        bit w;
        bit iv;
        bit dv;
        bit dwe;
        bit we;
        int p;
        int sel;
        logic [31:0] ia;
        logic [31:0] da;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(1, 3);
            iv = (sel != 2);
            dv = (sel != 1);
            ia = $urandom;
            da = $urandom;
            dwe = 1'($urandom_range(0, 1));
            grant(iv, dv, ia, da, dwe, 0, w);
            we = w && dwe;
            serve(w, we, w ? align(da) : align(ia), $urandom_range(0, 2), 1, 16'h0, 1'b0, p);
            n_chk++;
            if (p != (we ? LW : 0)) begin
                n_fail++;
                $display("FAIL rand_write_pulses iter %0d: got %0d, required %0d", i, p, we ? LW : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_round_robin();
        test_writeback();
        test_idle_ignore();
        test_cmd_stall();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester memory arbiter that shares the single external memory port between the instruction-fetch refill path and the data-cache refill/writeback path of the RISC-V core. Each granted request is one cache-line burst of LINE_WORDS beats: the arbiter latches the line address, issues it to memory, then counts read beats to the owner or write beats from it. Ties are resolved round-robin so neither side starves, and each requester stalls its pipeline stage on the ready/valid handshakes.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, beat width; must be 32
- LINE_WORDS, 4, beats per burst; a power of two, at least 2
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ic_req_valid  in  1  instruction line read requested
- ic_req_addr  in  ADDR_W  byte address inside the requested line
- ic_req_ready  out  1  instruction request accepted this cycle
- ic_resp_valid  out  1  instruction read beat valid
- ic_resp_last  out  1  final instruction beat
- dc_req_valid  in  1  data line request
- dc_req_addr  in  ADDR_W  byte address inside the line
- dc_req_we  in  1  1 = line writeback, 0 = line read
- dc_req_ready  out  1  data request accepted this cycle
- dc_wdata  in  DATA_W  current writeback beat
- dc_wdata_ready  out  1  current writeback beat consumed
- dc_resp_valid  out  1  data read beat valid
- dc_resp_last  out  1  final data read beat
- resp_data  out  DATA_W  read beat data, shared by both owners
- mem_req_valid  out  1  burst command valid
- mem_req_ready  in  1  burst command accepted
- mem_req_addr  out  ADDR_W  line-aligned burst address
- mem_req_we  out  1  burst direction
- mem_rdata_valid  in  1  memory read beat valid
- mem_rdata  in  DATA_W  memory read beat data
- mem_wdata  out  DATA_W  write beat data; equals dc_wdata
- mem_wdata_ready  in  1  memory accepts the write beat

## Operation
- States: IDLE, CMD, BEAT. Registers: `owner` (IC/DC), `we_q`, `addr_q`, `beat_cnt` (log2(LINE_WORDS) bits), `last_grant`.
- IDLE, arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the one that is not `last_grant` is granted.
  - The granted requester's ready is driven combinationally in the same cycle.
  - On the grant edge:
    - `addr_q` = address with the low log2(LINE_WORDS)+2 bits cleared.
    - `owner` and `last_grant` = the granted requester.
    - `we_q` = dc_req_we for DC, 0 for IC.
    - State goes to CMD.
- CMD:
  - mem_req_valid = 1, mem_req_addr = `addr_q`, mem_req_we = `we_q`; all three are held stable until mem_req_ready.
  - When mem_req_ready = 1, go to BEAT with `beat_cnt` = 0.
- BEAT, read (`we_q` = 0): each mem_rdata_valid is one beat.
  - resp_data is registered from mem_rdata.
  - The owner's resp_valid pulses one cycle later.
  - resp_last is set on beat LINE_WORDS-1.
- BEAT, write (`we_q` = 1):
  - dc_wdata_ready = mem_wdata_ready.
  - Each cycle with mem_wdata_ready = 1 is one beat.
- On each beat, `beat_cnt` increments. On beat LINE_WORDS-1, state returns to IDLE; the counter wraps to 0.
- Ignored inputs:
  - mem_rdata_valid in IDLE or CMD, or during a write burst.
  - mem_wdata_ready outside a write burst.
- A requester is never preempted mid-burst. The losing requester's ready stays 0 until the next IDLE.

## Timing
- Reset values:
  - All outputs 0, resp_data 0.
  - State IDLE, `last_grant` = IC, so the first tie goes to DC.
  - `beat_cnt` 0, `owner` IC, `addr_q` 0, `we_q` 0.
- Reset mid-burst aborts immediately. No further resp_valid or dc_wdata_ready is produced, including the registered beat in flight.
- Latency:
  - Grant (IDLE) to mem_req_valid: 1 cycle.
  - Read beat to resp_valid: 1 cycle.
  - Write beat: 0 cycles (combinational pass-through).
- The final read beat's resp_valid appears in the IDLE cycle, concurrently with a possible new grant.
- Minimum request-to-request spacing: the IDLE cycle plus the CMD cycle(s).

## Structure
- Package `mem_arb_pkg`:
  - state enum {IDLE, CMD, BEAT}
  - owner enum {OWN_IC, OWN_DC}
  - function computing the offset width from LINE_WORDS
- One sub-module, `rr_arb2`: 2-way round-robin grant logic with the `last_grant` register and an update enable.
- Counter and FSM live in `mem_arb`.

## Test plan
- IC only, ic_req_addr = 0x1000_0014, mem_req_ready held 1, four read beats 0xA0..0xA3 → mem_req_addr = 0x1000_0010; four ic_resp_valid with resp_data 0xA0..0xA3; ic_resp_last only on the 4th.
- IC and DC both valid from reset → DC granted first. A second simultaneous request afterwards → IC granted. A third → DC.
- DC writeback at 0x2000_0040, mem_wdata_ready toggled 1,0,1,1,0,1 → exactly 4 dc_wdata_ready pulses matching the 1s; return to IDLE after the 4th.
- mem_req_ready held 0 for 5 cycles in CMD → mem_req_valid, addr and we stay stable all 5 cycles; no beats counted.
- Stray mem_rdata_valid in IDLE → no resp_valid. rst asserted after beat 2 of a read → next cycle all outputs 0, state IDLE; the following tie grants DC.
